// File: rtl/rx_frame_if.sv
// rx_frame_if: symbol stream between syn, the frame controller and demodulation.
// master = the frame controller, slave = the surrounding syn/demod pair.
interface rx_frame_if #(
  parameter int AD_CVER_WIDTH = 12
);
  logic                     s_valid;
  logic [AD_CVER_WIDTH-1:0] s_data;
  logic                     s_ready;
  logic                     m_valid;
  logic [AD_CVER_WIDTH-1:0] m_data;
  logic                     m_last;
  logic                     m_ready;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frame sequencer between the sync and demodulation stages of the PAM receiver.
// Define RX_FRAME_CTRL_REG_OUT_EN for a registered 2-entry skid buffer on the m side.
//
// state     | meaning
// IDLE      | waiting for cfg_start
// ARM       | one-cycle syn_arm pulse, symbol counter and watchdog cleared
// WAIT_SYNC | waiting for the first symbol from syn, watchdog running
// STREAM    | passing LENGTH_DATA symbols, watchdog restarts on each transfer
// GAP       | GAP_CYC empty cycles after a frame, then re-arm or stop
module rx_frame_ctrl #(
  parameter int AD_CVER_WIDTH = 12,
  parameter int LENGTH_DATA   = 1024,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int GAP_CYC       = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic                 cfg_cont,
  input  logic [CNT_WIDTH-1:0] cfg_num_frames,
  output logic                 syn_arm,
  rx_frame_if.master           strm,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 err_timeout
);

  localparam int SW = $clog2(LENGTH_DATA);
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [WW-1:0] WD_LOAD  = WW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_SYNC, STREAM, GAP} state_t;

  state_t               state;
  logic [SW-1:0]        sym_cnt;
  logic [WW-1:0]        wd_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [CNT_WIDTH-1:0] target;
  logic                 stop_lat;

  logic en, last_beat, s_fire, m_fire, buf_empty;

  assign en        = (state == WAIT_SYNC) || (state == STREAM);
  assign last_beat = (sym_cnt == SW'(LENGTH_DATA - 1));
  assign syn_arm   = (state == ARM);
  assign busy      = (state != IDLE);

`ifdef RX_FRAME_CTRL_REG_OUT_EN
  logic [AD_CVER_WIDTH-1:0] buf_data [2];
  logic [1:0]               buf_last;
  logic [1:0]               buf_cnt;
  logic                     wr_ptr, rd_ptr;

  assign buf_empty    = (buf_cnt == 2'd0);
  assign strm.s_ready = en && (buf_cnt != 2'd2);
  assign strm.m_valid = !buf_empty;
  assign strm.m_data  = buf_data[rd_ptr];
  assign strm.m_last  = !buf_empty && buf_last[rd_ptr];
  assign s_fire       = strm.s_valid && strm.s_ready;
  assign m_fire       = strm.m_valid && strm.m_ready;

  // last flag is tagged on the s side so an aborted frame drains with m_last=0
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      buf_cnt     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
    end else begin
      if (s_fire) begin
        buf_data[wr_ptr] <= strm.s_data;
        buf_last[wr_ptr] <= last_beat;
        wr_ptr           <= !wr_ptr;
      end
      if (m_fire) rd_ptr <= !rd_ptr;
      if (s_fire && !m_fire)      buf_cnt <= buf_cnt + 2'd1;
      else if (m_fire && !s_fire) buf_cnt <= buf_cnt - 2'd1;
    end
  end
`else
  assign buf_empty    = 1'b1;
  assign strm.s_ready = strm.m_ready && en;
  assign strm.m_valid = strm.s_valid && en;
  assign strm.m_data  = en ? strm.s_data : '0;
  assign strm.m_last  = strm.m_valid && last_beat;
  assign s_fire       = strm.s_valid && strm.s_ready;
  assign m_fire       = strm.m_valid && strm.m_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sym_cnt     <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      target      <= '0;
      stop_lat    <= 1'b0;
      frame_cnt   <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      if (m_fire && strm.m_last) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end
      if (cfg_stop) stop_lat <= 1'b1;
      if (s_fire)   sym_cnt  <= sym_cnt + 1'b1;

      case (state)
        IDLE: begin
          stop_lat <= 1'b0;
          if (cfg_start) begin
            state     <= ARM;
            frame_cnt <= '0;
            stop_lat  <= cfg_stop;
            target    <= (cfg_num_frames == '0) ? CNT_WIDTH'(1) : cfg_num_frames;
          end
        end
        ARM: begin
          state   <= WAIT_SYNC;
          sym_cnt <= '0;
          wd_cnt  <= WD_LOAD;
        end
        WAIT_SYNC: begin
          // an offered symbol takes priority so a start+stop pair still yields one frame
          if (strm.s_valid) begin
            state  <= STREAM;
            wd_cnt <= WD_LOAD;
          end else if (stop_lat) begin
            state <= IDLE;
          end else if (wd_cnt == '0) begin
            err_timeout <= 1'b1;
            state       <= ARM;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        STREAM: begin
          if (s_fire) begin
            wd_cnt <= WD_LOAD;
            if (last_beat) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else if (wd_cnt == '0) begin
            err_timeout <= 1'b1;
            state       <= ARM;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        GAP: begin
          if (buf_empty) begin
            if (gap_cnt == '0) begin
              if (stop_lat || (!cfg_cont && frame_cnt == target)) state <= IDLE;
              else                                                  state <= ARM;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
